regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the multi-port register file.
//   RF_WIDTH / RF_DEPTH / RF_NR_RD : default data width, register count and
//                                    read-port count used by system wiring.
//   RF_AW                          : address width matching RF_DEPTH.
//   rf_wr_t                        : bundled write port (en, addr, data) for
//                                    connecting execute / load-return paths.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_WIDTH = 8;
    localparam int RF_DEPTH = 8;
    localparam int RF_NR_RD = 2;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef struct packed {
        logic                en;
        logic [RF_AW-1:0]    addr;
        logic [RF_WIDTH-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register busy bits tracking loads that have issued but not returned.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   rd_addr  [NR_RD][AW] : read-port addresses to report busy status for
//   mark_en / mark_addr  : set busy for a newly issued load
//   clr_en  / clr_addr   : load return, clears busy (and bypasses rd_busy)
//   rd_busy  [NR_RD]     : addressed register is still waiting on a load
//   any_busy             : OR of the busy flops (no same-cycle clear bypass)
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH = RF_DEPTH,
    parameter  int NR_RD = RF_NR_RD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NR_RD-1:0][AW-1:0]  rd_addr,
    input  logic                      mark_en,
    input  logic [AW-1:0]             mark_addr,
    input  logic                      clr_en,
    input  logic [AW-1:0]             clr_addr,
    output logic [NR_RD-1:0]          rd_busy,
    output logic                      any_busy
);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] set_s;
    logic [DEPTH-1:0] clr_s;
    logic [DEPTH-1:0] busy_nxt_s;

    // Decode mark/clear into per-register vectors; set is applied after
    // clear so a new load issued on the returning register stays pending.
    always_comb begin
        set_s = {DEPTH{1'b0}};
        clr_s = {DEPTH{1'b0}};
        for (int r = 0; r < DEPTH; r++) begin
            set_s[r] = mark_en && (mark_addr == AW'(r));
            clr_s[r] = clr_en  && (clr_addr  == AW'(r));
        end
        busy_nxt_s = (busy_r & ~clr_s) | set_s;
    end

    // Busy flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Per-port busy lookup; a load returning this cycle hides the stall.
    always_comb begin
        rd_busy = {NR_RD{1'b0}};
        for (int i = 0; i < NR_RD; i++) begin
            rd_busy[i] = busy_r[rd_addr[i]] &
                         ~(clr_en && (clr_addr == rd_addr[i]));
        end
    end

    // Summary flag from the flops only.
    always_comb begin
        any_busy = |busy_r;
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised register file with NR_RD combinational read ports, two write
// ports (execute = port 0, load return = port 1), write-through bypass, an
// optional hard-wired zero register and a pending-load busy scoreboard.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   rd_addr  [NR_RD][AW]           : read addresses
//   rd_data  [NR_RD][WIDTH]        : read data (combinational, bypassed)
//   rd_busy  [NR_RD]               : addressed register has a pending load
//   wr0_en / wr0_addr / wr0_data   : execute write port (wins collisions)
//   wr1_en / wr1_addr / wr1_data   : load-return write port, clears busy
//   mark_en / mark_addr            : mark a register busy for a new load
//   any_busy                       : any register busy (flop state only)
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = RF_WIDTH,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int NR_RD    = RF_NR_RD,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NR_RD-1:0][AW-1:0]    rd_addr,
    output logic [NR_RD-1:0][WIDTH-1:0] rd_data,
    output logic [NR_RD-1:0]            rd_busy,
    input  logic                        wr0_en,
    input  logic [AW-1:0]               wr0_addr,
    input  logic [WIDTH-1:0]            wr0_data,
    input  logic                        wr1_en,
    input  logic [AW-1:0]               wr1_addr,
    input  logic [WIDTH-1:0]            wr1_data,
    input  logic                        mark_en,
    input  logic [AW-1:0]               mark_addr,
    output logic                        any_busy
);

    localparam bit HAS_ZERO = (ZERO_REG != 32'sd0);

    logic [WIDTH-1:0] mem_r     [DEPTH];
    logic [WIDTH-1:0] mem_nxt_s [DEPTH];
    logic             mark_ok_s;

    // Next storage contents: port 0 has priority on an address collision,
    // and the zero register (when enabled) is pinned at 0.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            if (HAS_ZERO && (r == 32'sd0)) begin
                mem_nxt_s[r] = {WIDTH{1'b0}};
            end else if (wr0_en && (wr0_addr == AW'(r))) begin
                mem_nxt_s[r] = wr0_data;
            end else if (wr1_en && (wr1_addr == AW'(r))) begin
                mem_nxt_s[r] = wr1_data;
            end else begin
                mem_nxt_s[r] = mem_r[r];
            end
        end
    end

    // Storage flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_r[r] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_r[r] <= mem_nxt_s[r];
            end
        end
    end

    // Read muxes. Bypass is suppressed while reset is asserted so every port
    // shows the reset value immediately, matching the discarded writes.
    always_comb begin
        for (int i = 0; i < NR_RD; i++) begin
            if (HAS_ZERO && (rd_addr[i] == {AW{1'b0}})) begin
                rd_data[i] = {WIDTH{1'b0}};
            end else if (rst_n && wr0_en && (wr0_addr == rd_addr[i])) begin
                rd_data[i] = wr0_data;
            end else if (rst_n && wr1_en && (wr1_addr == rd_addr[i])) begin
                rd_data[i] = wr1_data;
            end else begin
                rd_data[i] = mem_r[rd_addr[i]];
            end
        end
    end

    // Marks on the zero register are dropped so it can never become busy.
    always_comb begin
        if (HAS_ZERO && (mark_addr == {AW{1'b0}})) begin
            mark_ok_s = 1'b0;
        end else begin
            mark_ok_s = mark_en;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NR_RD (NR_RD)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .mark_en   (mark_ok_s),
        .mark_addr (mark_addr),
        .clr_en    (wr1_en),
        .clr_addr  (wr1_addr),
        .rd_busy   (rd_busy),
        .any_busy  (any_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Drives two register files (ZERO_REG=0 and ZERO_REG=1) with identical
// stimulus and checks them against an array-based model of the register
// contents and pending-load bits, plus directed literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int NR = 2;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n = 1'b1;
    logic [NR-1:0][AW-1:0]    rd_addr;
    logic                     wr0_en, wr1_en, mark_en;
    logic [AW-1:0]            wr0_addr, wr1_addr, mark_addr;
    logic [W-1:0]             wr0_data, wr1_data;

    logic [NR-1:0][W-1:0]     rd_data0, rd_data1;
    logic [NR-1:0]            rd_busy0, rd_busy1;
    logic                     any_busy0, any_busy1;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_on  = 1'b0;

    // Model state: index 0 = plain file, index 1 = zero-register file.
    logic [W-1:0] m_mem  [2][D];
    bit           m_busy [2][D];

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NR_RD(NR), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_busy(rd_busy0), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data), .mark_en(mark_en), .mark_addr(mark_addr),
        .any_busy(any_busy0)
    );

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NR_RD(NR), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_busy(rd_busy1), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data), .mark_en(mark_en), .mark_addr(mark_addr),
        .any_busy(any_busy1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update: later assignments win, so port 0 beats port 1 and a new
    // mark beats a same-cycle load return.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int z = 0; z < 2; z++) begin
                for (int r = 0; r < D; r++) begin
                    m_mem[z][r]  <= '0;
                    m_busy[z][r] <= 1'b0;
                end
            end
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (wr1_en) m_mem[z][wr1_addr] <= wr1_data;
                if (wr0_en) m_mem[z][wr0_addr] <= wr0_data;
                if (wr1_en) m_busy[z][wr1_addr] <= 1'b0;
                if (mark_en && !(z == 1 && mark_addr == 3'd0)) m_busy[z][mark_addr] <= 1'b1;
                if (z == 1) m_mem[1][0] <= '0;
            end
        end
    end

    function automatic logic [W-1:0] exp_data(int z, logic [AW-1:0] a);
        if (!rst_n) return '0;
        if (z == 1 && a == 3'd0) return '0;
        if (wr0_en && wr0_addr == a) return wr0_data;
        if (wr1_en && wr1_addr == a) return wr1_data;
        return m_mem[z][a];
    endfunction

    function automatic logic exp_busy(int z, logic [AW-1:0] a);
        if (!rst_n) return 1'b0;
        if (wr1_en && wr1_addr == a) return 1'b0;
        return m_busy[z][a];
    endfunction

    function automatic logic exp_any(int z);
        logic acc;
        acc = 1'b0;
        for (int r = 0; r < D; r++) acc = acc | m_busy[z][r];
        return rst_n & acc;
    endfunction

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("model rd_data dut0 p%0d", i), 32'(rd_data0[i]), 32'(exp_data(0, rd_addr[i])));
                chk($sformatf("model rd_data dut1 p%0d", i), 32'(rd_data1[i]), 32'(exp_data(1, rd_addr[i])));
                chk($sformatf("model rd_busy dut0 p%0d", i), 32'(rd_busy0[i]), 32'(exp_busy(0, rd_addr[i])));
                chk($sformatf("model rd_busy dut1 p%0d", i), 32'(rd_busy1[i]), 32'(exp_busy(1, rd_addr[i])));
            end
            chk("model any_busy dut0", 32'(any_busy0), 32'(exp_any(0)));
            chk("model any_busy dut1", 32'(any_busy1), 32'(exp_any(1)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en  = 1'b0;
        wr1_en  = 1'b0;
        mark_en = 1'b0;
    endtask

    initial begin
        idle();
        rd_addr   = '0;
        wr0_addr  = '0; wr0_data = '0;
        wr1_addr  = '0; wr1_data = '0;
        mark_addr = '0;
        #1 rst_n = 1'b0;
        #1 cmp_on = 1'b1;

        // Reset held: every address reads 0 and nothing is busy.
        for (int a = 0; a < D; a++) begin
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(D - 1 - a);
            #1;
            chk("reset rd_data", 32'(rd_data0[0]), 32'd0);
            chk("reset rd_busy", 32'(rd_busy0[1]), 32'd0);
            chk("reset any_busy", 32'(any_busy0), 32'd0);
        end
        cyc();
        rst_n = 1'b1;

        // Write then read back, plus same-cycle bypass.
        cyc();
        wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 8'd63;
        rd_addr[0] = 3'd2; rd_addr[1] = 3'd1;
        #2 chk("bypass wr0 a2", 32'(rd_data0[0]), 32'd63);
        cyc(); idle();
        #2 chk("stored a2", 32'(rd_data0[0]), 32'd63);
        chk("untouched a1", 32'(rd_data0[1]), 32'd0);

        // Same-address collision: port 0 wins.
        cyc();
        wr0_en = 1'b1; wr0_addr = 3'd4; wr0_data = 8'd31;
        wr1_en = 1'b1; wr1_addr = 3'd4; wr1_data = 8'd99;
        rd_addr[0] = 3'd4;
        #2 chk("collision bypass", 32'(rd_data0[0]), 32'd31);
        cyc(); idle();
        #2 chk("collision stored", 32'(rd_data0[0]), 32'd31);

        // Different-address dual write.
        cyc();
        wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 8'd5;
        wr1_en = 1'b1; wr1_addr = 3'd6; wr1_data = 8'd7;
        rd_addr[0] = 3'd3; rd_addr[1] = 3'd6;
        cyc(); idle();
        #2 chk("dual a3", 32'(rd_data0[0]), 32'd5);
        chk("dual a6", 32'(rd_data0[1]), 32'd7);

        // Mark, then load return bypasses the stall.
        cyc();
        mark_en = 1'b1; mark_addr = 3'd5; rd_addr[0] = 3'd5;
        #2 chk("mark not yet visible", 32'(rd_busy0[0]), 32'd0);
        cyc(); idle();
        #2 chk("mark busy", 32'(rd_busy0[0]), 32'd1);
        chk("mark any_busy", 32'(any_busy0), 32'd1);
        cyc();
        wr1_en = 1'b1; wr1_addr = 3'd5; wr1_data = 8'd200;
        #2 chk("return busy bypass", 32'(rd_busy0[0]), 32'd0);
        chk("return data bypass", 32'(rd_data0[0]), 32'd200);
        chk("return any_busy still", 32'(any_busy0), 32'd1);
        cyc(); idle();
        #2 chk("after return busy", 32'(rd_busy0[0]), 32'd0);
        chk("after return any", 32'(any_busy0), 32'd0);

        // Mark and return on the same register: stays busy.
        cyc();
        mark_en = 1'b1; mark_addr = 3'd7;
        wr1_en = 1'b1; wr1_addr = 3'd7; wr1_data = 8'd11;
        rd_addr[0] = 3'd7;
        cyc(); idle();
        #2 chk("mark+ret busy", 32'(rd_busy0[0]), 32'd1);
        chk("mark+ret data", 32'(rd_data0[0]), 32'd11);
        cyc();
        wr1_en = 1'b1; wr1_addr = 3'd7; wr1_data = 8'd12;
        cyc(); idle();
        #2 chk("a7 cleared any", 32'(any_busy0), 32'd0);

        // Zero register: writes and marks ignored.
        cyc();
        wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 8'd255;
        mark_en = 1'b1; mark_addr = 3'd0; rd_addr[0] = 3'd0;
        #2 chk("zr same-cycle data", 32'(rd_data1[0]), 32'd0);
        chk("plain same-cycle data", 32'(rd_data0[0]), 32'd255);
        cyc(); idle();
        #2 chk("zr data", 32'(rd_data1[0]), 32'd0);
        chk("zr busy", 32'(rd_busy1[0]), 32'd0);
        chk("zr any_busy", 32'(any_busy1), 32'd0);
        chk("plain a0 busy", 32'(rd_busy0[0]), 32'd1);
        cyc();
        wr1_en = 1'b1; wr1_addr = 3'd0; wr1_data = 8'd1;
        cyc(); idle();

        // Asynchronous reset in the middle of a write.
        wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 8'd77; rd_addr[0] = 3'd2;
        #1 rst_n = 1'b0;
        #1 chk("async reset data", 32'(rd_data0[0]), 32'd0);
        chk("async reset any", 32'(any_busy0), 32'd0);
        cyc();
        rst_n = 1'b1; idle();
        cyc();
        #2 chk("post-reset a2 dut0", 32'(rd_data0[0]), 32'd0);
        chk("post-reset a2 dut1", 32'(rd_data1[0]), 32'd0);

        // Randomised traffic with occasional reset pulses.
        repeat (500) begin
            cyc();
            rst_n     = ($urandom_range(0, 99) != 0);
            wr0_en    = ($urandom_range(0, 1) == 1);
            wr1_en    = ($urandom_range(0, 2) == 0);
            mark_en   = ($urandom_range(0, 2) == 0);
            wr0_addr  = AW'($urandom_range(0, D - 1));
            wr1_addr  = AW'($urandom_range(0, D - 1));
            mark_addr = AW'($urandom_range(0, D - 1));
            wr0_data  = W'($urandom);
            wr1_data  = W'($urandom);
            rd_addr[0] = AW'($urandom_range(0, D - 1));
            rd_addr[1] = AW'($urandom_range(0, D - 1));
        end
        cyc();
        rst_n = 1'b1; idle();
        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
